rx_header_sequencer_ble: RTL and testbench

- Sequences one BLE RX header through the HEC-check datapath (bit FIFO + de-HEC).
- Latches per-packet config and gates incoming header bits into the FIFO write side.
- Then drains the FIFO through the de-HEC, waits for completion and reports a one-cycle status (HEC result, length check).
- Sits between the RX demod/deframer and the HEC+FIFO datapath; driven by the link-layer control FSM.

---
 rtl/ble_rx_pkg.sv | 13 +
 rtl/rx_hdr_bit_counter_ble.sv | 28 ++
 rtl/rx_header_sequencer_ble.sv | 150 +++++++++++++++
 tb/tb_rx_header_sequencer_ble.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ble_rx_pkg.sv
// rtl/ble_rx_pkg.sv - shared constants and state encoding for the BLE RX header sequencer
package ble_rx_pkg;
  localparam int NB_W_DEF           = 16;
  localparam int NA_W_DEF           = 14;
  localparam int HEC_BITS           = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
endpackage

// File: rtl/rx_hdr_bit_counter_ble.sv
// rtl/rx_hdr_bit_counter_ble.sv - loadable up-counter with equality flag (bit count and watchdog)
module rx_hdr_bit_counter_ble #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_cmp_val,
  output logic [W-1:0] o_count,
  output logic         o_eq
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_eq    = (r_count == i_cmp_val);
endmodule

// File: rtl/rx_header_sequencer_ble.sv
// rtl/rx_header_sequencer_ble.sv - sequences one BLE RX header through FIFO + de-HEC; watchdog via RX_HDR_SEQ_TIMEOUT_EN
module rx_header_sequencer_ble
  import ble_rx_pkg::*;
#(
  parameter int NB_W           = NB_W_DEF,
  parameter int NA_W           = NA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [NB_W-1:0] n_bits_cfg,
  input  logic [7:0]      uap_dci_cfg,
  input  logic            rx_valid,
  input  logic            rx_bit,
  output logic            dp_valid_in,
  output logic            dp_data_in,
  output logic            dp_enable,
  output logic [7:0]      dp_uap_dci,
  output logic [NB_W-1:0] dp_n_bits,
  input  logic            dp_finished,
  input  logic            dp_flag,
  input  logic [NA_W-1:0] dp_num_after_hec,
  output logic            busy,
  output logic            done,
  output logic            hec_ok,
  output logic            len_err,
  output logic            timeout_err
);
  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [NB_W-1:0] r_n_bits;
  logic [7:0]      r_uap_dci;
  logic            r_hec_ok;
  logic            r_len_err;
  logic            r_timeout_err;
  logic [NB_W-1:0] w_bit_cnt;
  logic            w_bit_eq;
  logic            w_bit_inc;
  logic            w_last_bit;
  logic            w_wd_exp;
  logic            w_start_ok;
  logic [NB_W-1:0] w_exp_len;

  assign w_start_ok = start && !abort;
  assign w_bit_inc  = (r_state == S_LOAD) && rx_valid;
  // Compare against n-1 so the bit that reaches n_bits ends LOAD in its own cycle.
  assign w_last_bit = w_bit_inc && w_bit_eq;
  assign w_exp_len  = r_n_bits - NB_W'(HEC_BITS);

  rx_hdr_bit_counter_ble #(.W(NB_W)) u_bit_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state == S_IDLE),
    .i_load_val ('0),
    .i_inc      (w_bit_inc),
    .i_cmp_val  (r_n_bits - NB_W'(1)),
    .o_count    (w_bit_cnt),
    .o_eq       (w_bit_eq)
  );

`ifdef RX_HDR_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] w_wd_cnt;
  logic            w_wd_eq;

  rx_hdr_bit_counter_ble #(.W(WD_W)) u_wd_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state != S_DRAIN),
    .i_load_val ('0),
    .i_inc      ((r_state == S_DRAIN) && !w_wd_eq),
    .i_cmp_val  (WD_W'(TIMEOUT_CYCLES)),
    .o_count    (w_wd_cnt),
    .o_eq       (w_wd_eq)
  );
  assign w_wd_exp = (r_state == S_DRAIN) && w_wd_eq;
`else
  assign w_wd_exp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next = (n_bits_cfg != '0) ? S_LOAD : S_REPORT;
      end
      S_LOAD: begin
        if (abort)           w_next = S_IDLE;
        else if (w_last_bit) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)            w_next = S_IDLE;
        else if (dp_finished) w_next = S_CHECK;
        else if (w_wd_exp)    w_next = S_REPORT;
      end
      S_CHECK:  w_next = abort ? S_IDLE : S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    dp_valid_in = (r_state == S_LOAD) && rx_valid;
    dp_data_in  = (r_state == S_LOAD) && rx_bit;
    dp_enable   = (r_state == S_DRAIN) && !w_wd_exp;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_REPORT);
  end

  // Status registers change only on entry to REPORT, so they hold between done pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_n_bits      <= '0;
      r_uap_dci     <= '0;
      r_hec_ok      <= 1'b0;
      r_len_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_start_ok && n_bits_cfg != '0) begin
        r_n_bits  <= n_bits_cfg;
        r_uap_dci <= uap_dci_cfg;
      end
      if (r_state != S_REPORT && w_next == S_REPORT) begin
        r_hec_ok      <= (r_state == S_CHECK) && !dp_flag;
        r_len_err     <= (r_state == S_IDLE) ||
                         ((r_state == S_CHECK) && (dp_num_after_hec != w_exp_len[NA_W-1:0]));
        r_timeout_err <= (r_state == S_DRAIN);
      end
    end
  end

  assign dp_n_bits   = r_n_bits;
  assign dp_uap_dci  = r_uap_dci;
  assign hec_ok      = r_hec_ok;
  assign len_err     = r_len_err;
  assign timeout_err = r_timeout_err;

  logic w_unused;
  assign w_unused = ^w_bit_cnt;
endmodule

// File: tb/tb_rx_header_sequencer_ble.sv
// tb/tb_rx_header_sequencer_ble.sv - directed self-checking bench for rx_header_sequencer_ble
module tb_rx_header_sequencer_ble;
  localparam int NB_W = 16;
  localparam int NA_W = 14;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start, abort;
  logic [NB_W-1:0] n_bits_cfg;
  logic [7:0]      uap_dci_cfg;
  logic            rx_valid, rx_bit;
  logic            dp_valid_in, dp_data_in, dp_enable;
  logic [7:0]      dp_uap_dci;
  logic [NB_W-1:0] dp_n_bits;
  logic            dp_finished, dp_flag;
  logic [NA_W-1:0] dp_num_after_hec;
  logic            busy, done, hec_ok, len_err, timeout_err;

  int total = 0;
  int bad   = 0;
  int vcnt = 0, ones_cnt = 0, en_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  rx_header_sequencer_ble #(.NB_W(NB_W), .NA_W(NA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .n_bits_cfg(n_bits_cfg), .uap_dci_cfg(uap_dci_cfg),
    .rx_valid(rx_valid), .rx_bit(rx_bit),
    .dp_valid_in(dp_valid_in), .dp_data_in(dp_data_in), .dp_enable(dp_enable),
    .dp_uap_dci(dp_uap_dci), .dp_n_bits(dp_n_bits),
    .dp_finished(dp_finished), .dp_flag(dp_flag), .dp_num_after_hec(dp_num_after_hec),
    .busy(busy), .done(done), .hec_ok(hec_ok), .len_err(len_err), .timeout_err(timeout_err)
  );

  always @(posedge clk) begin
    if (dp_valid_in) vcnt++;
    if (dp_valid_in && dp_data_in) ones_cnt++;
    if (dp_enable) en_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pat_bit(input int i);
    return (i ^ (i >> 2)) & 1;
  endfunction

  function automatic int pat_ones(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += pat_bit(i);
    return s;
  endfunction

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_bit   = pat_bit(i[31:0]) != 0;
      tick();
    end
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
  endtask

  task automatic run_header(input string tag, input int ncfg, input int nsend,
                            input logic flag, input int nah, input logic start_in_drain,
                            input logic exp_hec, input logic exp_len);
    int v0, o0, d0;
    v0 = vcnt; o0 = ones_cnt; d0 = done_cnt;
    start = 1'b1; n_bits_cfg = ncfg[NB_W-1:0]; uap_dci_cfg = 8'h5A;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_nbits"}, dp_n_bits, ncfg);
    chk({tag, "_uap"}, dp_uap_dci, 8'h5A);
    send_bits(nsend);
    chk({tag, "_drain_en"}, dp_enable, 1);
    for (int c = 0; c < 4; c++) begin
      start = start_in_drain && (c == 1);
      tick();
    end
    start = 1'b0;
    dp_finished = 1'b1; dp_flag = flag; dp_num_after_hec = nah[NA_W-1:0];
    tick();
    dp_finished = 1'b0;
    chk({tag, "_check_en"}, dp_enable, 0);
    chk({tag, "_check_nodone"}, done, 0);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hec_ok"}, hec_ok, exp_hec);
    chk({tag, "_len_err"}, len_err, exp_len);
    chk({tag, "_to_err"}, timeout_err, 0);
    tick();
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hec_hold"}, hec_ok, exp_hec);
    chk({tag, "_fwd_cnt"}, vcnt - v0, ncfg);
    chk({tag, "_fwd_ones"}, ones_cnt - o0, pat_ones(ncfg));
    chk({tag, "_ndone"}, done_cnt - d0, 1);
  endtask

  initial begin
    int v0, e0, d0, cyc;
    reset = 1'b0; start = 1'b0; abort = 1'b0; n_bits_cfg = '0; uap_dci_cfg = '0;
    rx_valid = 1'b0; rx_bit = 1'b0; dp_finished = 1'b0; dp_flag = 1'b0; dp_num_after_hec = '0;
    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", dp_enable, 0);
    chk("rst_hec", hec_ok, 0);
    chk("rst_len", len_err, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_nbits", dp_n_bits, 0);
    chk("rst_uap", dp_uap_dci, 0);
    reset = 1'b1;
    tick();

    run_header("nom", 54, 54, 1'b0, 46, 1'b0, 1'b1, 1'b0);
    run_header("hecfail", 54, 54, 1'b1, 46, 1'b0, 1'b0, 1'b0);
    run_header("lenbad", 54, 54, 1'b0, 45, 1'b0, 1'b1, 1'b1);

    // zero-length header
    v0 = vcnt; e0 = en_cnt; d0 = done_cnt;
    start = 1'b1; n_bits_cfg = '0;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 6) begin tick(); cyc++; end
    chk("zero_lat_ok", cyc <= 2, 1);
    chk("zero_done", done, 1);
    chk("zero_len", len_err, 1);
    chk("zero_hec", hec_ok, 0);
    tick();
    chk("zero_nofwd", vcnt - v0, 0);
    chk("zero_noen", en_cnt - e0, 0);
    chk("zero_ndone", done_cnt - d0, 1);
    chk("zero_len_hold", len_err, 1);

    // abort mid-LOAD, then a clean header
    d0 = done_cnt;
    start = 1'b1; n_bits_cfg = 16'd54;
    tick();
    start = 1'b0;
    send_bits(20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    tick(); tick(); tick();
    chk("abort_nodone", done_cnt - d0, 0);
    chk("abort_cfg_kept", dp_n_bits, 54);
    run_header("post_abort", 54, 54, 1'b0, 46, 1'b0, 1'b1, 1'b0);

    run_header("extra", 54, 60, 1'b0, 46, 1'b1, 1'b1, 1'b0);

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1; n_bits_cfg = 16'd10;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", busy, 0);

    // reset mid-LOAD
    start = 1'b1; n_bits_cfg = 16'd30;
    tick();
    start = 1'b0;
    send_bits(5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_nbits", dp_n_bits, 0);

    // drain without dp_finished
    e0 = en_cnt; d0 = done_cnt;
    start = 1'b1; n_bits_cfg = 16'd8;
    tick();
    start = 1'b0;
    send_bits(8);
`ifdef RX_HDR_SEQ_TIMEOUT_EN
    cyc = 0;
    while (!done && cyc < 100) begin tick(); cyc++; end
    chk("to_done", done, 1);
    chk("to_en_cycles", en_cnt - e0, TO);
    chk("to_err", timeout_err, 1);
    chk("to_hec", hec_ok, 0);
    chk("to_len", len_err, 0);
    tick();
    chk("to_idle", busy, 0);
`else
    for (int c = 0; c < 40; c++) tick();
    chk("nowd_busy", busy, 1);
    chk("nowd_en", dp_enable, 1);
    chk("nowd_nodone", done_cnt - d0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("nowd_abort_en", dp_enable, 0);
    chk("nowd_to_err", timeout_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
